// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_if
// Description : Upstream op handshake, ALU drive/return and downstream result
//               handshake bundle for alu_issue_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_shamt;

    logic [31:0] alu_operand1;
    logic [31:0] alu_operand2;
    logic [4:0]  alu_sr_amount;
    logic [14:0] alu_strobe;
    logic [31:0] alu_result;
    logic        alu_zlc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zlc;
    logic        out_err;
    logic        busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_shamt,
        output alu_result, alu_zlc, out_ready,
        input  in_ready, alu_operand1, alu_operand2, alu_sr_amount, alu_strobe,
        input  out_valid, out_result, out_zlc, out_err, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_shamt,
        input  alu_result, alu_zlc, out_ready,
        output in_ready, alu_operand1, alu_operand2, alu_sr_amount, alu_strobe,
        output out_valid, out_result, out_zlc, out_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issue stage in front of the 32-bit ALU: registers one op,
//               holds one-hot strobe/operands for the op latency, returns the
//               captured result downstream. ALU_ISSUE_OVERLAP_EN lets a new op
//               be accepted in the same cycle the previous result is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_issue_if.slave bus
);

    localparam logic [3:0] c_OP_MUL     = 4'd2;
    localparam logic [3:0] c_OP_DIV     = 4'd3;
    localparam logic [3:0] c_OP_MOD     = 4'd4;
    localparam logic [3:0] c_OP_ILLEGAL = 4'd15;
    localparam logic [5:0] c_MUL_CNT    = 6'(MUL_LAT - 1);
    localparam logic [5:0] c_DIV_CNT    = 6'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        zlc_q, zlc_d;
    logic        err_q, err_d;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_exec;
    logic [5:0]  w_cnt_init;
    logic [14:0] w_strobe;

    // Overlap lets DONE hand its result off and take the next op on one edge.
`ifdef ALU_ISSUE_OVERLAP_EN
    assign w_in_ready = (state_q == ST_IDLE) ||
                        ((state_q == ST_DONE) && bus.out_ready);
`else
    assign w_in_ready = (state_q == ST_IDLE);
`endif

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_exec   = (state_q == ST_EXEC);

    always_comb begin
        w_cnt_init = 6'd0;
        if (bus.in_op == c_OP_MUL) begin
            w_cnt_init = c_MUL_CNT;
        end else if ((bus.in_op == c_OP_DIV) || (bus.in_op == c_OP_MOD)) begin
            w_cnt_init = c_DIV_CNT;
        end
    end

    for (genvar n = 0; n < 15; n++) begin : g_strobe
        assign w_strobe[n] = w_exec && (op_q == 4'(n));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            shamt_q  <= 5'd0;
            cnt_q    <= 6'd0;
            result_q <= 32'd0;
            zlc_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shamt_q  <= shamt_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zlc_q    <= zlc_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        shamt_d  = shamt_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zlc_d    = zlc_q;
        err_d    = err_q;

        case (state_q)
            ST_EXEC: begin
                if (cnt_q == 6'd0) begin
                    result_d = bus.alu_result;
                    zlc_d    = bus.alu_zlc;
                    err_d    = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // A new op overrides the DONE->IDLE step when overlap is enabled.
        if (w_accept) begin
            op_d    = bus.in_op;
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            shamt_d = bus.in_shamt;
            if (bus.in_op == c_OP_ILLEGAL) begin
                result_d = 32'd0;
                zlc_d    = 1'b0;
                err_d    = 1'b1;
                cnt_d    = 6'd0;
                state_d  = ST_DONE;
            end else begin
                cnt_d   = w_cnt_init;
                state_d = ST_EXEC;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.alu_operand1  = a_q;
    assign bus.alu_operand2  = b_q;
    assign bus.alu_sr_amount = shamt_q;
    assign bus.alu_strobe    = w_strobe;
    assign bus.out_valid     = (state_q == ST_DONE);
    assign bus.out_result    = result_q;
    assign bus.out_zlc       = zlc_q;
    assign bus.out_err       = err_q;
    assign bus.busy          = (state_q != ST_IDLE);

    a_strobe_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(w_strobe));
    a_strobe_exec_only: assert property (@(posedge clk) disable iff (reset)
        (w_strobe != 15'd0) |-> w_exec);

endmodule
`default_nettype wire
